// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying one register-file word per transfer.
// The master drives the beat fields; the slave answers with out_ready.
interface regfile_dump_if #(
    parameter int DATA_W = 64
) ();
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_idx, output out_data, output out_last,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_idx, input  out_data, input  out_last,
                    output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Streams a frozen snapshot of the register file as one beat per register,
// optionally followed by an XOR checksum beat, then pulses done.
module regfile_dump #(
    parameter int NREGS     = 15,
    parameter int DATA_W    = 64,
    parameter int EMIT_CSUM = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NREGS*DATA_W-1:0] regs_flat,
    regfile_dump_if.master          out_if,
    output logic                    busy,
    output logic                    done
);

    // Index 4'hF is reserved to tag the checksum beat.
    if (NREGS < 1 || NREGS > 15) begin : g_nregs_check
        $error("regfile_dump: NREGS must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SEND, CSUM, FIN} state_e;

    localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [DATA_W-1:0] snap_q [NREGS];
    logic [DATA_W-1:0] snap_d [NREGS];
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] live_xor;

    logic              valid;
    logic [3:0]        beat_idx;
    logic [DATA_W-1:0] beat_data;
    logic              beat_last;
    logic              xfer;

    assign xfer = valid & out_if.out_ready;

    // NOTE: every variable gets a default before any branch so no latch can be inferred.
    always_comb begin
        live_xor = '0;
        for (int i = 0; i < NREGS; i++) begin
            live_xor = live_xor ^ regs_flat[i*DATA_W +: DATA_W];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (xfer && idx_q == LAST_IDX) state_d = (EMIT_CSUM != 0) ? CSUM : FIN;
            CSUM:    if (xfer) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot and checksum are captured together on the start edge.
    always_comb begin
        idx_d  = idx_q;
        snap_d = snap_q;
        csum_d = csum_q;
        if (state_q == IDLE && start) begin
            for (int i = 0; i < NREGS; i++) begin
                snap_d[i] = regs_flat[i*DATA_W +: DATA_W];
            end
            csum_d = live_xor;
            idx_d  = 4'd0;
        end else if (state_q == SEND && xfer) begin
            idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
        end
    end

    // Outputs are pure functions of registered state, so they hold while stalled.
    always_comb begin
        valid     = 1'b0;
        beat_idx  = 4'd0;
        beat_data = '0;
        beat_last = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            SEND: begin
                valid     = 1'b1;
                busy      = 1'b1;
                beat_idx  = idx_q;
                beat_data = snap_q[idx_q];
                beat_last = (EMIT_CSUM == 0) && (idx_q == LAST_IDX);
            end
            CSUM: begin
                valid     = 1'b1;
                busy      = 1'b1;
                beat_idx  = 4'hF;
                beat_data = csum_q;
                beat_last = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign out_if.out_valid = valid;
    assign out_if.out_idx   = beat_idx;
    assign out_if.out_data  = beat_data;
    assign out_if.out_last  = beat_last;

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the snapshot is cleared on reset because it is part of the defined reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            csum_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: two instances (with and without checksum)
// checked every cycle against a snapshot/beat-count reference model.
module tb_regfile_dump;

    localparam int NREGS  = 15;
    localparam int DATA_W = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              st;
    logic [1:0]              rdy;
    logic [NREGS*DATA_W-1:0] regs_flat;

    logic [1:0]        v, lst, bsy, dn;
    logic [3:0]        ix [2];
    logic [DATA_W-1:0] dt [2];

    regfile_dump_if #(.DATA_W(DATA_W)) if0 ();
    regfile_dump_if #(.DATA_W(DATA_W)) if1 ();

    regfile_dump #(.NREGS(NREGS), .DATA_W(DATA_W), .EMIT_CSUM(1)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .regs_flat(regs_flat),
        .out_if(if0), .busy(bsy[0]), .done(dn[0]));

    regfile_dump #(.NREGS(NREGS), .DATA_W(DATA_W), .EMIT_CSUM(0)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .regs_flat(regs_flat),
        .out_if(if1), .busy(bsy[1]), .done(dn[1]));

    assign if0.out_ready = rdy[0];
    assign if1.out_ready = rdy[1];
    assign v[0]  = if0.out_valid;
    assign v[1]  = if1.out_valid;
    assign lst[0] = if0.out_last;
    assign lst[1] = if1.out_last;
    assign ix[0] = if0.out_idx;
    assign ix[1] = if1.out_idx;
    assign dt[0] = if0.out_data;
    assign dt[1] = if1.out_data;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 streaming, 2 done cycle.
    int                cyc = 0;
    bit                mon_en = 1'b0;
    int                ph [2];
    int                nb [2];
    int                acc_cyc [2];
    int                done_cyc [2];
    int                done_cnt [2];
    logic [DATA_W-1:0] last_csum [2];
    logic [DATA_W-1:0] snap_m [2][NREGS];
    int                hold4 = 0;
    int                tot;
    logic [3:0]        e_idx;
    logic [DATA_W-1:0] e_data;
    logic              e_last;

    initial begin
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; nb[k] = 0; acc_cyc[k] = 0; done_cyc[k] = 0; done_cnt[k] = 0;
            last_csum[k] = '0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (v[0] && ix[0] == 4'd4) hold4++;
            for (int k = 0; k < 2; k++) begin
                tot = NREGS + ((k == 0) ? 1 : 0);
                check($sformatf("u%0d.valid", k), v[k], ph[k] == 1);
                check($sformatf("u%0d.busy", k), bsy[k], ph[k] == 1);
                check($sformatf("u%0d.done", k), dn[k], ph[k] == 2);
                if (ph[k] == 1 && v[k]) begin
                    if (nb[k] < NREGS) begin
                        e_idx  = 4'(nb[k]);
                        e_data = snap_m[k][nb[k]];
                        e_last = (k == 1) && (nb[k] == NREGS - 1);
                    end else begin
                        e_idx  = 4'hF;
                        e_data = '0;
                        for (int i = 0; i < NREGS; i++) e_data = e_data ^ snap_m[k][i];
                        e_last = 1'b1;
                    end
                    check($sformatf("u%0d.idx b%0d", k, nb[k]), ix[k], e_idx);
                    check($sformatf("u%0d.data b%0d", k, nb[k]), dt[k], e_data);
                    check($sformatf("u%0d.last b%0d", k, nb[k]), lst[k], e_last);
                end
                if (dn[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                end
                if (rst) begin
                    ph[k] = 0;
                end else if (ph[k] == 1) begin
                    if (rdy[k]) begin
                        if (nb[k] == NREGS) last_csum[k] = dt[k];
                        nb[k]++;
                        if (nb[k] == tot) ph[k] = 2;
                    end
                end else if (ph[k] == 2) begin
                    ph[k] = 0;
                end else if (st[k]) begin
                    for (int i = 0; i < NREGS; i++) snap_m[k][i] = regs_flat[i*DATA_W +: DATA_W];
                    nb[k]      = 0;
                    ph[k]      = 1;
                    acc_cyc[k] = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k);
        tick();
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input string tag);
        int n = 0;
        while (ph[k] != 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, " finished"}, ph[k] == 0, 1'b1);
    endtask

    task automatic load_index_regs();
        for (int i = 0; i < NREGS; i++) regs_flat[i*DATA_W +: DATA_W] = 64'(i);
    endtask

    task automatic load_random_regs();
        for (int i = 0; i < NREGS; i++) regs_flat[i*DATA_W +: DATA_W] = {$urandom, $urandom};
    endtask

    int dc;

    initial begin
        // Reset with random inputs, including start.
        rst = 1'b1;
        st  = 2'($urandom);
        rdy = 2'($urandom);
        load_random_regs();
        @(posedge clk);
        mon_en = 1'b1;
        #1;
        st  = 2'b11;
        rdy = 2'($urandom);
        load_random_regs();
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst u%0d valid", k), v[k], 1'b0);
            check($sformatf("rst u%0d idx", k), ix[k], 4'd0);
            check($sformatf("rst u%0d data", k), dt[k], 64'd0);
            check($sformatf("rst u%0d last", k), lst[k], 1'b0);
            check($sformatf("rst u%0d busy", k), bsy[k], 1'b0);
            check($sformatf("rst u%0d done", k), dn[k], 1'b0);
        end
        rst = 1'b0;
        st  = 2'b00;
        rdy = 2'b11;
        tick();
        check("start during rst ignored", bsy[0], 1'b0);

        // Basic dump, reg i = i.
        load_index_regs();
        pulse(0);
        wait_idle(0, "basic");
        check("basic latency", 64'(done_cyc[0] - acc_cyc[0]), 64'd17);
        check("basic csum", last_csum[0], 64'd15);

        // Backpressure on idx 4.
        hold4 = 0;
        pulse(0);
        repeat (4) tick();
        check("bp idx4 present", ix[0], 4'd4);
        rdy[0] = 1'b0;
        repeat (3) tick();
        rdy[0] = 1'b1;
        wait_idle(0, "bp");
        check("bp idx4 hold cycles", 64'(hold4), 64'd4);
        check("bp csum", last_csum[0], 64'd15);

        // Snapshot isolation and start while busy.
        dc = done_cnt[0];
        pulse(0);
        for (int i = 0; i < NREGS; i++) regs_flat[i*DATA_W +: DATA_W] = 64'hDEAD;
        repeat (6) tick();
        check("iso idx6 present", ix[0], 4'd6);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        wait_idle(0, "iso");
        repeat (4) tick();
        check("iso done count", 64'(done_cnt[0] - dc), 64'd1);
        check("iso csum", last_csum[0], 64'd15);

        // Reset while idx 7 is valid.
        load_index_regs();
        dc = done_cnt[0];
        pulse(0);
        repeat (7) tick();
        check("mid-rst idx7 present", ix[0], 4'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-rst valid", v[0], 1'b0);
        check("mid-rst busy", bsy[0], 1'b0);
        repeat (5) tick();
        check("mid-rst no done", 64'(done_cnt[0] - dc), 64'd0);
        pulse(0);
        check("restart idx0", ix[0], 4'd0);
        wait_idle(0, "restart");
        check("restart done count", 64'(done_cnt[0] - dc), 64'd1);
        check("restart latency", 64'(done_cyc[0] - acc_cyc[0]), 64'd17);

        // No-checksum instance.
        load_index_regs();
        pulse(1);
        wait_idle(1, "nocsum");
        check("nocsum latency", 64'(done_cyc[1] - acc_cyc[1]), 64'd16);

        // Random data, random backpressure, random starts and live register changes.
        for (int n = 0; n < 6; n++) begin
            load_random_regs();
            for (int c = 0; c < 60; c++) begin
                tick();
                rdy = 2'($urandom);
                st  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
                if ($urandom_range(0, 3) == 0) load_random_regs();
            end
            st  = 2'b00;
            rdy = 2'b11;
            wait_idle(0, "random u0");
            wait_idle(1, "random u1");
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
